// File: rtl/sc_psr_windowed_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sc_psr_windowed_pkg
// Purpose  : Shared constants for the windowed processor status register:
//            PSR bit positions, reset values and the CWP field width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sc_psr_windowed_pkg;

  // Width of the current-window-pointer field in the packed PSR word
  localparam int CWP_WIDTH = 5;

  // Bit positions inside the packed 32-bit PSR word
  localparam int PSR_ICC_HI = 23;
  localparam int PSR_ICC_LO = 20;
  localparam int PSR_S      = 7;
  localparam int PSR_PS     = 6;
  localparam int PSR_ET     = 5;
  localparam int PSR_CWP_HI = 4;
  localparam int PSR_CWP_LO = 0;

  // Reset values
  localparam logic [3:0] ICC_RESET = 4'b1111;
  localparam logic       S_RESET   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sc_psr_windowed_if.sv
`default_nettype none
// ============================================================================
// Module   : sc_psr_windowed_if
// Purpose  : Bundles the ALU flag inputs, control-unit commands, write data
//            bus and all status / trap-pulse outputs of the PSR block.
// Ports    : master - control side (drives commands, observes status)
//            slave  - PSR side (receives commands, drives status)
// Revision : 1.0 - initial release
// ============================================================================
interface sc_psr_windowed_if
  import sc_psr_windowed_pkg::*;
#(
  parameter int NWINDOWS = 8
);

  logic                 SC_PsrWin_negativo;
  logic                 SC_PsrWin_cero;
  logic                 SC_PsrWin_overflow;
  logic                 SC_PsrWin_carry;
  logic                 SC_PsrWin_IccWrite_InLow;
  logic                 SC_PsrWin_Save_InHigh;
  logic                 SC_PsrWin_Restore_InHigh;
  logic                 SC_PsrWin_Trap_InHigh;
  logic                 SC_PsrWin_Rett_InHigh;
  logic                 SC_PsrWin_WrPsr_InHigh;
  logic                 SC_PsrWin_WrWim_InHigh;
  logic [31:0]          SC_PsrWin_Data_In;

  logic [3:0]           SC_PsrWin_Icc_Out;
  logic [CWP_WIDTH-1:0] SC_PsrWin_Cwp_Out;
  logic [NWINDOWS-1:0]  SC_PsrWin_Wim_Out;
  logic                 SC_PsrWin_S_Out;
  logic                 SC_PsrWin_Ps_Out;
  logic                 SC_PsrWin_Et_Out;
  logic [31:0]          SC_PsrWin_Psr_Out;
  logic                 SC_PsrWin_WinOvf_Out;
  logic                 SC_PsrWin_WinUnf_Out;
  logic                 SC_PsrWin_Illegal_Out;
  logic                 SC_PsrWin_Error_Out;

  modport master (
    output SC_PsrWin_negativo, SC_PsrWin_cero, SC_PsrWin_overflow, SC_PsrWin_carry,
           SC_PsrWin_IccWrite_InLow, SC_PsrWin_Save_InHigh, SC_PsrWin_Restore_InHigh,
           SC_PsrWin_Trap_InHigh, SC_PsrWin_Rett_InHigh, SC_PsrWin_WrPsr_InHigh,
           SC_PsrWin_WrWim_InHigh, SC_PsrWin_Data_In,
    input  SC_PsrWin_Icc_Out, SC_PsrWin_Cwp_Out, SC_PsrWin_Wim_Out, SC_PsrWin_S_Out,
           SC_PsrWin_Ps_Out, SC_PsrWin_Et_Out, SC_PsrWin_Psr_Out, SC_PsrWin_WinOvf_Out,
           SC_PsrWin_WinUnf_Out, SC_PsrWin_Illegal_Out, SC_PsrWin_Error_Out
  );

  modport slave (
    input  SC_PsrWin_negativo, SC_PsrWin_cero, SC_PsrWin_overflow, SC_PsrWin_carry,
           SC_PsrWin_IccWrite_InLow, SC_PsrWin_Save_InHigh, SC_PsrWin_Restore_InHigh,
           SC_PsrWin_Trap_InHigh, SC_PsrWin_Rett_InHigh, SC_PsrWin_WrPsr_InHigh,
           SC_PsrWin_WrWim_InHigh, SC_PsrWin_Data_In,
    output SC_PsrWin_Icc_Out, SC_PsrWin_Cwp_Out, SC_PsrWin_Wim_Out, SC_PsrWin_S_Out,
           SC_PsrWin_Ps_Out, SC_PsrWin_Et_Out, SC_PsrWin_Psr_Out, SC_PsrWin_WinOvf_Out,
           SC_PsrWin_WinUnf_Out, SC_PsrWin_Illegal_Out, SC_PsrWin_Error_Out
  );

endinterface
`default_nettype wire

// File: rtl/sc_psr_cwp_counter.sv
`default_nettype none
// ============================================================================
// Module   : sc_psr_cwp_counter
// Purpose  : Computes the neighbouring window indices (CWP-1 and CWP+1,
//            modulo NWINDOWS) and the WIM bit at each candidate index.
// Ports    : cwp        - current window pointer
//            wim        - window invalid mask
//            cwp_dec    - (cwp - 1) mod NWINDOWS
//            cwp_inc    - (cwp + 1) mod NWINDOWS
//            wim_at_dec - wim[cwp_dec]
//            wim_at_inc - wim[cwp_inc]
// Revision : 1.0 - initial release
// ============================================================================
module sc_psr_cwp_counter
  import sc_psr_windowed_pkg::*;
#(
  parameter int NWINDOWS  = 8,
  parameter int CWP_WIDTH = 5
) (
  input  logic [CWP_WIDTH-1:0] cwp,
  input  logic [NWINDOWS-1:0]  wim,
  output logic [CWP_WIDTH-1:0] cwp_dec,
  output logic [CWP_WIDTH-1:0] cwp_inc,
  output logic                 wim_at_dec,
  output logic                 wim_at_inc
);

  localparam logic [CWP_WIDTH-1:0] LAST = CWP_WIDTH'(NWINDOWS - 1);

  // Explicit wrap at both ends: a plain modulo-2^n counter would walk into
  // nonexistent windows whenever NWINDOWS is not a power of two.
  always_comb begin
    cwp_dec = (cwp == '0)   ? LAST : cwp - 1'b1;
    cwp_inc = (cwp >= LAST) ? '0   : cwp + 1'b1;
  end

  // Mux the mask bit by comparison so the index width never has to match
  // the (possibly non-power-of-two) mask width.
  always_comb begin
    wim_at_dec = 1'b0;
    wim_at_inc = 1'b0;
    for (int i = 0; i < NWINDOWS; i++) begin
      if (cwp_dec == CWP_WIDTH'(i)) wim_at_dec = wim[i];
      if (cwp_inc == CWP_WIDTH'(i)) wim_at_inc = wim[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sc_psr_windowed.sv
`default_nettype none
// ============================================================================
// Module   : sc_psr_windowed
// Purpose  : Processor status register with register-window management:
//            condition codes, CWP, WIM, S/PS/ET, one-cycle trap pulses and a
//            sticky error mode. All state updates on the falling clock edge.
// Ports    : SC_PsrWin_CLOCK_50     - clock (falling edge active)
//            SC_PsrWin_RESET_InHigh - synchronous active-high reset
//            bus                    - command/flag inputs and status outputs
// Revision : 1.0 - initial release
// ============================================================================
module sc_psr_windowed
  import sc_psr_windowed_pkg::*;
#(
  parameter int NWINDOWS  = 8,
  parameter int CWP_WIDTH = 5
) (
  input  logic                  SC_PsrWin_CLOCK_50,
  input  logic                  SC_PsrWin_RESET_InHigh,
  sc_psr_windowed_if.slave      bus
);

  logic [3:0]           icc;
  logic [CWP_WIDTH-1:0] cwp;
  logic [NWINDOWS-1:0]  wim;
  logic                 s, ps, et, err;
  logic                 win_ovf, win_unf, illegal;

  logic [CWP_WIDTH-1:0] cwp_dec, cwp_inc;
  logic                 wim_at_dec, wim_at_inc;
  logic                 wr_psr_bad, wr_psr_accept;
  logic [31:0]          psr;
  logic                 unused_data;

  sc_psr_cwp_counter #(
    .NWINDOWS  (NWINDOWS),
    .CWP_WIDTH (CWP_WIDTH)
  ) u_cwp_counter (
    .cwp        (cwp),
    .wim        (wim),
    .cwp_dec    (cwp_dec),
    .cwp_inc    (cwp_inc),
    .wim_at_dec (wim_at_dec),
    .wim_at_inc (wim_at_inc)
  );

  // A PSR write naming a window that does not exist is rejected entirely.
  assign wr_psr_bad = 32'(bus.SC_PsrWin_Data_In[PSR_CWP_HI:PSR_CWP_LO]) >= 32'(NWINDOWS);

  // WrPsr acts only when nothing of higher priority is present and the
  // write is legal; only then does it take the icc field from the bus.
  assign wr_psr_accept = !err && !bus.SC_PsrWin_Trap_InHigh && !bus.SC_PsrWin_Rett_InHigh &&
                         bus.SC_PsrWin_WrPsr_InHigh && !wr_psr_bad;

  always_ff @(negedge SC_PsrWin_CLOCK_50) begin
    if (SC_PsrWin_RESET_InHigh) begin
      icc     <= ICC_RESET;
      cwp     <= '0;
      wim     <= '0;
      s       <= S_RESET;
      ps      <= 1'b0;
      et      <= 1'b0;
      err     <= 1'b0;
      win_ovf <= 1'b0;
      win_unf <= 1'b0;
      illegal <= 1'b0;
    end else begin
      win_ovf <= 1'b0;
      win_unf <= 1'b0;
      illegal <= 1'b0;

      if (wr_psr_accept) begin
        icc <= bus.SC_PsrWin_Data_In[PSR_ICC_HI:PSR_ICC_LO];
      end else if (!bus.SC_PsrWin_IccWrite_InLow) begin
        icc <= {bus.SC_PsrWin_negativo, bus.SC_PsrWin_cero,
                bus.SC_PsrWin_overflow, bus.SC_PsrWin_carry};
      end

      // Error mode freezes everything except the flag path above.
      if (!err) begin
        if (bus.SC_PsrWin_WrWim_InHigh) wim <= bus.SC_PsrWin_Data_In[NWINDOWS-1:0];

        if (bus.SC_PsrWin_Trap_InHigh) begin
          if (et) begin
            et  <= 1'b0;
            ps  <= s;
            s   <= 1'b1;
            cwp <= cwp_dec;
          end else begin
            err <= 1'b1;
          end
        end else if (bus.SC_PsrWin_Rett_InHigh) begin
          if (et || !s)        illegal <= 1'b1;
          else if (wim_at_inc) win_unf <= 1'b1;
          else begin
            et  <= 1'b1;
            s   <= ps;
            cwp <= cwp_inc;
          end
        end else if (bus.SC_PsrWin_WrPsr_InHigh) begin
          if (wr_psr_bad) begin
            illegal <= 1'b1;
          end else begin
            s   <= bus.SC_PsrWin_Data_In[PSR_S];
            ps  <= bus.SC_PsrWin_Data_In[PSR_PS];
            et  <= bus.SC_PsrWin_Data_In[PSR_ET];
            cwp <= bus.SC_PsrWin_Data_In[PSR_CWP_HI:PSR_CWP_LO];
          end
        end else if (bus.SC_PsrWin_Save_InHigh && bus.SC_PsrWin_Restore_InHigh) begin
          illegal <= 1'b1;
        end else if (bus.SC_PsrWin_Save_InHigh) begin
          if (wim_at_dec) win_ovf <= 1'b1;
          else            cwp     <= cwp_dec;
        end else if (bus.SC_PsrWin_Restore_InHigh) begin
          if (wim_at_inc) win_unf <= 1'b1;
          else            cwp     <= cwp_inc;
        end
      end
    end
  end

  always_comb begin
    psr                         = '0;
    psr[PSR_ICC_HI:PSR_ICC_LO]  = icc;
    psr[PSR_S]                  = s;
    psr[PSR_PS]                 = ps;
    psr[PSR_ET]                 = et;
    psr[PSR_CWP_HI:PSR_CWP_LO]  = cwp;
  end

  // Only part of the data bus is architecturally meaningful.
  assign unused_data = ^bus.SC_PsrWin_Data_In;

  assign bus.SC_PsrWin_Icc_Out     = icc;
  assign bus.SC_PsrWin_Cwp_Out     = cwp;
  assign bus.SC_PsrWin_Wim_Out     = wim;
  assign bus.SC_PsrWin_S_Out       = s;
  assign bus.SC_PsrWin_Ps_Out      = ps;
  assign bus.SC_PsrWin_Et_Out      = et;
  assign bus.SC_PsrWin_Psr_Out     = psr;
  assign bus.SC_PsrWin_WinOvf_Out  = win_ovf;
  assign bus.SC_PsrWin_WinUnf_Out  = win_unf;
  assign bus.SC_PsrWin_Illegal_Out = illegal;
  assign bus.SC_PsrWin_Error_Out   = err;

endmodule
`default_nettype wire

// File: tb/tb_sc_psr_windowed.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_psr_windowed
// Purpose  : Self-checking bench for sc_psr_windowed with NWINDOWS=8 and
//            NWINDOWS=5 instances, directed steps followed by random traffic,
//            compared against a behavioural model of the PSR rules.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_psr_windowed;

  typedef struct packed {
    logic [3:0]  icc;
    logic [4:0]  cwp;
    logic [31:0] wim;
    logic        s, ps, et, err, ovf, unf, ill;
  } model_t;

  typedef struct packed {
    logic        n, z, v, c, iccw_n;
    logic        save, restore, trap, rett, wrpsr, wrwim;
    logic [31:0] data;
  } cmd_t;

  localparam int OP_SAVE    = 1;
  localparam int OP_RESTORE = 2;
  localparam int OP_TRAP    = 4;
  localparam int OP_RETT    = 8;
  localparam int OP_WRPSR   = 16;
  localparam int OP_WRWIM   = 32;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  int     checks = 0;
  int     errors = 0;
  model_t mdl [2];

  always #5 clk = ~clk;

  sc_psr_windowed_if #(.NWINDOWS(8)) if8 ();
  sc_psr_windowed_if #(.NWINDOWS(5)) if5 ();

  sc_psr_windowed #(.NWINDOWS(8), .CWP_WIDTH(5)) dut8 (
    .SC_PsrWin_CLOCK_50     (clk),
    .SC_PsrWin_RESET_InHigh (rst),
    .bus                    (if8.slave)
  );

  sc_psr_windowed #(.NWINDOWS(5), .CWP_WIDTH(5)) dut5 (
    .SC_PsrWin_CLOCK_50     (clk),
    .SC_PsrWin_RESET_InHigh (rst),
    .bus                    (if5.slave)
  );

  function automatic model_t mreset();
    model_t m = '0;
    m.icc = 4'hF;
    m.s   = 1'b1;
    return m;
  endfunction

  // Behavioural statement of the PSR rules for one falling edge.
  function automatic model_t mstep(model_t m, cmd_t c, int nw);
    model_t r = m;
    int up = (int'(m.cwp) + 1) % nw;
    int dn = (int'(m.cwp) + nw - 1) % nw;
    bit psr_taken = 0;
    longint mask = (64'd1 << nw) - 1;
    r.ovf = 0; r.unf = 0; r.ill = 0;
    if (!m.err) begin
      if (c.wrwim) r.wim = 32'(longint'(c.data) & mask);
      if (c.trap) begin
        if (m.et) begin
          r.et = 0; r.ps = m.s; r.s = 1; r.cwp = 5'(dn);
        end else r.err = 1;
      end else if (c.rett) begin
        if (m.et || !m.s) r.ill = 1;
        else if (m.wim[up]) r.unf = 1;
        else begin r.et = 1; r.s = m.ps; r.cwp = 5'(up); end
      end else if (c.wrpsr) begin
        if (int'(c.data[4:0]) >= nw) r.ill = 1;
        else begin
          psr_taken = 1;
          r.icc = c.data[23:20]; r.s = c.data[7]; r.ps = c.data[6];
          r.et = c.data[5]; r.cwp = c.data[4:0];
        end
      end else if (c.save && c.restore) r.ill = 1;
      else if (c.save) begin
        if (m.wim[dn]) r.ovf = 1; else r.cwp = 5'(dn);
      end else if (c.restore) begin
        if (m.wim[up]) r.unf = 1; else r.cwp = 5'(up);
      end
    end
    if (!c.iccw_n && !psr_taken) r.icc = {c.n, c.z, c.v, c.c};
    return r;
  endfunction

  function automatic cmd_t mk(int ops, logic [31:0] d, int iccw = -1);
    cmd_t c = '0;
    c.save    = (ops & OP_SAVE) != 0;
    c.restore = (ops & OP_RESTORE) != 0;
    c.trap    = (ops & OP_TRAP) != 0;
    c.rett    = (ops & OP_RETT) != 0;
    c.wrpsr   = (ops & OP_WRPSR) != 0;
    c.wrwim   = (ops & OP_WRWIM) != 0;
    c.data    = d;
    c.iccw_n  = (iccw < 0);
    {c.n, c.z, c.v, c.c} = (iccw < 0) ? 4'h0 : iccw[3:0];
    return c;
  endfunction

  task automatic drive8(input cmd_t c);
    {if8.SC_PsrWin_negativo, if8.SC_PsrWin_cero, if8.SC_PsrWin_overflow, if8.SC_PsrWin_carry} = {c.n, c.z, c.v, c.c};
    if8.SC_PsrWin_IccWrite_InLow = c.iccw_n;
    if8.SC_PsrWin_Save_InHigh    = c.save;
    if8.SC_PsrWin_Restore_InHigh = c.restore;
    if8.SC_PsrWin_Trap_InHigh    = c.trap;
    if8.SC_PsrWin_Rett_InHigh    = c.rett;
    if8.SC_PsrWin_WrPsr_InHigh   = c.wrpsr;
    if8.SC_PsrWin_WrWim_InHigh   = c.wrwim;
    if8.SC_PsrWin_Data_In        = c.data;
  endtask

  task automatic drive5(input cmd_t c);
    {if5.SC_PsrWin_negativo, if5.SC_PsrWin_cero, if5.SC_PsrWin_overflow, if5.SC_PsrWin_carry} = {c.n, c.z, c.v, c.c};
    if5.SC_PsrWin_IccWrite_InLow = c.iccw_n;
    if5.SC_PsrWin_Save_InHigh    = c.save;
    if5.SC_PsrWin_Restore_InHigh = c.restore;
    if5.SC_PsrWin_Trap_InHigh    = c.trap;
    if5.SC_PsrWin_Rett_InHigh    = c.rett;
    if5.SC_PsrWin_WrPsr_InHigh   = c.wrpsr;
    if5.SC_PsrWin_WrWim_InHigh   = c.wrwim;
    if5.SC_PsrWin_Data_In        = c.data;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare(input int which, input string tag);
    model_t      e = mdl[which];
    logic [31:0] psr_o, fld_o, wim_o, pul_o;
    if (which == 0) begin
      psr_o = if8.SC_PsrWin_Psr_Out;
      fld_o = 32'({if8.SC_PsrWin_Icc_Out, if8.SC_PsrWin_Cwp_Out, if8.SC_PsrWin_S_Out, if8.SC_PsrWin_Ps_Out, if8.SC_PsrWin_Et_Out});
      wim_o = 32'(if8.SC_PsrWin_Wim_Out);
      pul_o = 32'({if8.SC_PsrWin_WinOvf_Out, if8.SC_PsrWin_WinUnf_Out, if8.SC_PsrWin_Illegal_Out, if8.SC_PsrWin_Error_Out});
    end else begin
      psr_o = if5.SC_PsrWin_Psr_Out;
      fld_o = 32'({if5.SC_PsrWin_Icc_Out, if5.SC_PsrWin_Cwp_Out, if5.SC_PsrWin_S_Out, if5.SC_PsrWin_Ps_Out, if5.SC_PsrWin_Et_Out});
      wim_o = 32'(if5.SC_PsrWin_Wim_Out);
      pul_o = 32'({if5.SC_PsrWin_WinOvf_Out, if5.SC_PsrWin_WinUnf_Out, if5.SC_PsrWin_Illegal_Out, if5.SC_PsrWin_Error_Out});
    end
    chk({tag, " psr"},    psr_o, {8'h00, e.icc, 12'h000, e.s, e.ps, e.et, e.cwp});
    chk({tag, " fields"}, fld_o, 32'({e.icc, e.cwp, e.s, e.ps, e.et}));
    chk({tag, " wim"},    wim_o, e.wim);
    chk({tag, " pulses"}, pul_o, 32'({e.ovf, e.unf, e.ill, e.err}));
  endtask

  // Apply one command to one instance (the other idles) for one falling
  // edge, then check that instance half a period later.
  task automatic run(input int which, input string tag, input cmd_t c, input logic r = 1'b0);
    cmd_t idle = mk(0, 32'h0);
    rst = r;
    drive8(which == 0 ? c : idle);
    drive5(which == 1 ? c : idle);
    @(negedge clk);
    if (r) begin
      mdl[0] = mreset();
      mdl[1] = mreset();
    end else begin
      mdl[which] = mstep(mdl[which], c, which == 0 ? 8 : 5);
    end
    @(posedge clk);
    compare(which, tag);
  endtask

  task automatic random_phase(input int which, input int steps);
    int nw = (which == 0) ? 8 : 5;
    for (int k = 0; k < steps; k++) begin
      int   ops = 0;
      cmd_t c;
      logic [31:0] d = $urandom;
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 3) == 0) ops |= (1 << b);
      d[4:0] = 5'($urandom_range(0, nw + 1));
      if (ops & OP_WRWIM) d = d & $urandom;
      c = mk(ops, d, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 15)));
      run(which, "random", c, $urandom_range(0, 49) == 0);
    end
  endtask

  initial begin
    mdl[0] = mreset();
    mdl[1] = mreset();

    // NWINDOWS = 8
    run(0, "reset",         mk(0, 32'h0), 1'b1);
    run(0, "idle",          mk(0, 32'h0));
    run(0, "save_wrap",     mk(OP_SAVE, 32'h0));
    run(0, "restore_wrap",  mk(OP_RESTORE, 32'h0));
    run(0, "wim_80",        mk(OP_WRWIM, 32'h80));
    run(0, "save_ovf",      mk(OP_SAVE, 32'h0));
    run(0, "wim_02",        mk(OP_WRWIM, 32'h02));
    run(0, "restore_unf",   mk(OP_RESTORE, 32'h0));
    run(0, "wim_clr",       mk(OP_WRWIM, 32'h0));
    run(0, "wrpsr_et1",     mk(OP_WRPSR, 32'h00A0_0023));
    run(0, "trap",          mk(OP_TRAP, 32'h0));
    run(0, "rett",          mk(OP_RETT, 32'h0));
    run(0, "trap_save",     mk(OP_TRAP | OP_SAVE, 32'h0));
    run(0, "save_restore",  mk(OP_SAVE | OP_RESTORE, 32'h0));
    run(0, "wrpsr_bad",     mk(OP_WRPSR, 32'h00F0_0009, 5));
    run(0, "wrpsr_icc",     mk(OP_WRPSR, 32'h0030_0001, 12));
    run(0, "trap_et0",      mk(OP_TRAP, 32'h0));
    run(0, "err_save_icc",  mk(OP_SAVE, 32'h0, 6));
    run(0, "err_wrwim",     mk(OP_WRWIM, 32'hFF));
    run(0, "reset_clr",     mk(OP_SAVE | OP_RESTORE, 32'h0), 1'b1);

    // NWINDOWS = 5
    run(1, "n5_wrpsr",      mk(OP_WRPSR, 32'h0000_0024));
    run(1, "n5_restore",    mk(OP_RESTORE, 32'h0));
    run(1, "n5_wrpsr_bad",  mk(OP_WRPSR, 32'h0000_0005));
    run(1, "n5_save_wrap",  mk(OP_SAVE, 32'h0));
    run(1, "n5_wim_01",     mk(OP_WRWIM, 32'h01));
    run(1, "n5_restore_unf", mk(OP_RESTORE, 32'h0));

    random_phase(0, 400);
    random_phase(1, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
